// File: rtl/icache_fill_ctrl_pkg.sv
// Shared definitions for the icache refill engine: line/address geometry and FSM encodings.
// Used by icache_fill_ctrl and icache_line_asm.
package icache_fill_ctrl_pkg;

  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 15;
  localparam int TAG_HI  = 14;
  localparam int TAG_LO  = 8;
  localparam int IDX_HI  = 7;
  localparam int IDX_LO  = 5;
  localparam int OFS_HI  = 4;
  localparam int OFS_LO  = 0;
  localparam int OFS_W   = OFS_HI - OFS_LO + 1;
  localparam int LADDR_W = ADDR_W - OFS_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEAT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fill_state_t;

  // Line-aligned byte address from the {tag,index} line address.
  function automatic logic [ADDR_W-1:0] line_base(input logic [LADDR_W-1:0] laddr);
    return {laddr, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_line_asm.sv
// Beat assembly registers for one cache line; each beat register is written
// when beat_we is high and beat_sel selects it.
module icache_line_asm
  import icache_fill_ctrl_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_sel,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line
);

  localparam int BEATS = LINE_W / BEAT_W;

  logic [BEATS-1:0][BEAT_W-1:0] beats;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_we && (beat_sel == CNT_W'(i))) begin
          beats[i] <= beat_data;
        end
      end
    end
  end

  assign line = beats;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction cache refill engine: fetches a missed line in beats and writes it to the store.
// Optional `ICACHE_FILL_ERR_EN adds mem_err/fill_err and suppresses the store write on a bad line.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              hit,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rdvld,
  input  logic [BEAT_W-1:0] mem_rdata,
`ifdef ICACHE_FILL_ERR_EN
  input  logic              mem_err,
  output logic              fill_err,
`endif
  output logic [ADDR_W-1:0] st_addr,
  output logic [LINE_W-1:0] st_wrdata,
  output logic              st_wrvld
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  fill_state_t          state;
  fill_state_t          state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [LADDR_W-1:0]   line_addr;
  logic                 beat_we;
  logic                 last_beat;
  logic                 err_nx;
  logic                 unused_ofs;

  assign unused_ofs = ^fetch_addr[OFS_HI:OFS_LO];
  assign beat_we    = (state == ST_BEAT) && mem_rdvld;
  assign last_beat  = beat_we && (cnt == CNT_W'(BEATS - 1));

`ifdef ICACHE_FILL_ERR_EN
  logic err_flag;
  assign err_nx = (state == ST_IDLE) ? 1'b0 : (err_flag | (beat_we & mem_err));
`else
  assign err_nx = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (fetch_req && !hit) state_nx = ST_REQ;
      ST_REQ:   if (mem_ack) state_nx = ST_BEAT;
      ST_BEAT:  if (last_beat) state_nx = err_nx ? ST_DONE : ST_WRITE;
      ST_WRITE: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      line_addr <= '0;
      fill_busy <= 1'b0;
      mem_req   <= 1'b0;
      st_wrvld  <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nx;
      fill_busy <= (state_nx != ST_IDLE);
      mem_req   <= (state_nx == ST_REQ);
      st_wrvld  <= (state_nx == ST_WRITE);
      fill_done <= (state_nx == ST_DONE);
      if (state != ST_BEAT) begin
        cnt <= '0;
      end else if (mem_rdvld) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == ST_IDLE) && (state_nx == ST_REQ)) begin
        line_addr <= fetch_addr[ADDR_W-1:OFS_W];
      end else if (state_nx == ST_IDLE) begin
        line_addr <= '0;
      end
    end
  end

`ifdef ICACHE_FILL_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      err_flag <= err_nx;
      fill_err <= (state_nx == ST_DONE) && err_nx;
    end
  end
`endif

  assign mem_addr = line_base(line_addr);
  assign st_addr  = mem_addr;

  icache_line_asm #(
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_line_asm (
    .clk       (clk),
    .rst       (rst),
    .beat_we   (beat_we),
    .beat_sel  (cnt),
    .beat_data (mem_rdata),
    .line      (st_wrdata)
  );

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed testbench for icache_fill_ctrl; define ICACHE_FILL_ERR_EN to also exercise the error path.
module tb_icache_fill_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [14:0]   fetch_addr;
  logic          hit;
  logic          fill_busy;
  logic          fill_done;
  logic          mem_req;
  logic [14:0]   mem_addr;
  logic          mem_ack;
  logic          mem_rdvld;
  logic [63:0]   mem_rdata;
  logic [14:0]   st_addr;
  logic [255:0]  st_wrdata;
  logic          st_wrvld;
`ifdef ICACHE_FILL_ERR_EN
  logic          mem_err;
  logic          fill_err;
`endif

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  icache_fill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .hit        (hit),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdvld  (mem_rdvld),
    .mem_rdata  (mem_rdata),
`ifdef ICACHE_FILL_ERR_EN
    .mem_err    (mem_err),
    .fill_err   (fill_err),
`endif
    .st_addr    (st_addr),
    .st_wrdata  (st_wrdata),
    .st_wrvld   (st_wrvld)
  );

  always #5 clk = ~clk;

  // Counts store write strobes seen over the whole run.
  always @(negedge clk) begin
    if (st_wrvld === 1'b1) wr_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d);
    mem_rdvld = 1'b1;
    mem_rdata = d;
    tick();
    mem_rdvld = 1'b0;
    mem_rdata = '0;
  endtask

  // Presents a one-cycle miss and accepts the request immediately.
  task automatic apply_stimulus(input logic [14:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    hit        = 1'b0;
    tick();
    fetch_req  = 1'b0;
    mem_ack    = 1'b1;
    tick();
    mem_ack    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 0; fetch_addr = '0; hit = 0;
    mem_ack = 0; mem_rdvld = 0; mem_rdata = '0;
`ifdef ICACHE_FILL_ERR_EN
    mem_err = 0;
`endif
    #2 rst = 1'b0;
    #2;
    check_output("rst_busy", fill_busy, 0);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_wrdata", st_wrdata, 0);
    check_output("rst_wrvld", st_wrvld, 0);
    check_output("rst_done", fill_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

    // Basic miss with back-to-back beats
    fetch_req = 1; fetch_addr = 15'h1A3C; hit = 0;
    tick();
    check_output("basic_req", mem_req, 1);
    check_output("basic_mem_addr", mem_addr, 15'h1A20);
    check_output("basic_st_addr", st_addr, 15'h1A20);
    check_output("basic_busy", fill_busy, 1);
    fetch_req = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    check_output("basic_req_drop", mem_req, 0);
    for (int b = 0; b < 4; b++) beat(64'(b));
    check_output("basic_wrvld", st_wrvld, 1);
    check_output("basic_line", st_wrdata, {64'd3, 64'd2, 64'd1, 64'd0});
    check_output("basic_done_early", fill_done, 0);
    tick();
    check_output("basic_wrvld_off", st_wrvld, 0);
    check_output("basic_done", fill_done, 1);
    tick();
    check_output("basic_done_off", fill_done, 0);
    check_output("basic_idle_busy", fill_busy, 0);
    check_output("basic_idle_addr", mem_addr, 0);
    check_output("basic_wr_count", wr_count, 1);

    // Hits produce no activity
    fetch_req = 1; hit = 1; fetch_addr = 15'h1A3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("hit_quiet", {mem_req, fill_busy, st_wrvld}, 3'b000);
    end
    fetch_req = 0; hit = 0;

    // Handshakes in IDLE are ignored
    mem_ack = 1; mem_rdvld = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_ack = 0; mem_rdvld = 0; mem_rdata = '0;
    tick();
    check_output("idle_ignore_busy", fill_busy, 0);
    check_output("idle_ignore_line", st_wrdata, {64'd3, 64'd2, 64'd1, 64'd0});

    // Stalled ack, gapped beats, address change mid-fill
    fetch_req = 1; fetch_addr = 15'h1A3C; hit = 0;
    tick();
    fetch_req = 0;
    for (int i = 0; i < 4; i++) begin
      check_output("stall_req_held", mem_req, 1);
      tick();
    end
    check_output("stall_req_5th", mem_req, 1);
    mem_ack = 1; mem_rdvld = 1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    mem_ack = 0; mem_rdvld = 0;
    check_output("stall_req_drop", mem_req, 0);
    beat(64'h0123_4567_89AB_CDEF);
    tick();
    fetch_req = 1; fetch_addr = 15'h7FE0; hit = 0;
    beat(64'hFEDC_BA98_7654_3210);
    tick();
    tick();
    check_output("addrchg_st_addr", st_addr, 15'h1A20);
    check_output("addrchg_mem_addr", mem_addr, 15'h1A20);
    beat(64'hA5A5_A5A5_A5A5_A5A5);
    beat(64'h5A5A_5A5A_5A5A_5A5A);
    fetch_req = 0;
    check_output("stall_wrvld", st_wrvld, 1);
    check_output("stall_st_addr", st_addr, 15'h1A20);
    check_output("stall_line", st_wrdata,
      {64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5,
       64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
    tick();
    check_output("stall_done", fill_done, 1);
    tick();
    check_output("stall_idle", fill_busy, 0);
    check_output("stall_wr_count", wr_count, 2);

    // Reset in the middle of a fill
    apply_stimulus(15'h0440);
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    rst = 1'b0;
    #1;
    check_output("midrst_busy", fill_busy, 0);
    check_output("midrst_addr", mem_addr, 0);
    check_output("midrst_line", st_wrdata, 0);
    tick();
    tick();
    check_output("midrst_wrvld", st_wrvld, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    check_output("midrst_idle", fill_busy, 0);
    check_output("midrst_wr_count", wr_count, 2);
    apply_stimulus(15'h0460);
    check_output("restart_addr", mem_addr, 15'h0460);
    beat(64'hB0); beat(64'hB1); beat(64'hB2); beat(64'hB3);
    check_output("restart_wrvld", st_wrvld, 1);
    check_output("restart_line", st_wrdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    tick();
    tick();
    check_output("restart_wr_count", wr_count, 3);

`ifdef ICACHE_FILL_ERR_EN
    // Error on beat 2 suppresses the write
    apply_stimulus(15'h0140);
    beat(64'hC0); beat(64'hC1);
    mem_err = 1; beat(64'hC2); mem_err = 0;
    beat(64'hC3);
    check_output("err_wrvld", st_wrvld, 0);
    check_output("err_done", fill_done, 1);
    check_output("err_flag", fill_err, 1);
    tick();
    check_output("err_flag_off", fill_err, 0);
    check_output("err_idle", fill_busy, 0);
    check_output("err_wr_count", wr_count, 3);
    apply_stimulus(15'h0160);
    beat(64'hD0); beat(64'hD1); beat(64'hD2); beat(64'hD3);
    check_output("post_err_wrvld", st_wrvld, 1);
    check_output("post_err_line", st_wrdata, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
    tick();
    check_output("post_err_done", fill_done, 1);
    check_output("post_err_noerr", fill_err, 0);
    tick();
    check_output("post_err_wr_count", wr_count, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
